pet_vram_arbiter: RTL and testbench

Time-slot arbiter that shares the single-port 2 KB PET video RAM between the 6502 CPU bus and the 8 MHz video fetch engine. Each 1 µs character slot is divided into eight 8 MHz phases. One phase is reserved for the video character fetch and one for a CPU access. The block sits between the CPU bus decoder, the video timing generator and the video RAM macro. It presents a stable character byte to the video engine and a req/ack handshake to the CPU side.

---
 rtl/pet_vram_pkg.sv | 19 +
 rtl/pet_slot_phase.sv | 29 ++
 rtl/pet_vram_arbiter.sv | 113 +++++++++++
 tb/tb_pet_vram_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pet_vram_pkg.sv
// rtl/pet_vram_pkg.sv - shared widths, slot phase numbers and arbiter states for the PET video RAM arbiter
package pet_vram_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 8;

  localparam logic [2:0] PH_VID_ADDR  = 3'd0;
  localparam logic [2:0] PH_VID_LATCH = 3'd2;
  localparam logic [2:0] PH_CPU_GRANT = 3'd4;
  localparam logic [2:0] PH_WE_CLR    = 3'd5;
  localparam logic [2:0] PH_CPU_DONE  = 3'd6;

  typedef enum logic [1:0] {
    SYNC     = 2'd0,
    RUN_IDLE = 2'd1,
    RUN_BUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/pet_slot_phase.sv
// rtl/pet_slot_phase.sv - 8-phase slot counter; holds at phase 0 until the first 1 MHz enable
module pet_slot_phase
  import pet_vram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_8mp,
  input  logic       ce_1m,
  output logic [2:0] ph,
  output logic       run
);

  // ph holds the phase of the tick being processed; the ce_1m tick is phase 0,
  // so the counter re-aligns to 1 there on every 1 MHz enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph  <= PH_VID_ADDR;
      run <= 1'b0;
    end else if (ce_8mp) begin
      if (ce_1m) begin
        ph  <= 3'd1;
        run <= 1'b1;
      end else if (run) begin
        ph  <= ph + 3'd1;
      end
    end
  end

endmodule

// File: rtl/pet_vram_arbiter.sv
// rtl/pet_vram_arbiter.sv - PET video RAM time-slot arbiter (video fetch vs CPU); PET_SNOW_EN enables snow grant
module pet_vram_arbiter
  import pet_vram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_8mp,
  input  logic              ce_1m,
  input  logic              video_on,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q,
  output logic              snow_hit
);

  logic [2:0] ph;
  logic       run;
  logic       tick;
  logic       snow_mode;
  logic       acc_we;
  logic       acc_snow;
  logic [2:0] grant_ph;
  logic [2:0] done_ph;
  arb_state_e state;

  pet_slot_phase u_phase (
    .clk    (clk),
    .reset  (reset),
    .ce_8mp (ce_8mp),
    .ce_1m  (ce_1m),
    .ph     (ph),
    .run    (run)
  );

  assign tick = ce_8mp && (run || ce_1m);

`ifdef PET_SNOW_EN
  assign snow_mode = video_on;
`else
  // video_on has no effect here: the video fetch is never displaced
  assign snow_mode = video_on & 1'b0;
`endif

  assign grant_ph = snow_mode ? PH_VID_ADDR : PH_CPU_GRANT;
  assign done_ph  = acc_snow ? PH_VID_LATCH : PH_CPU_DONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SYNC;
      vid_data  <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_d     <= '0;
      snow_hit  <= 1'b0;
      acc_we    <= 1'b0;
      acc_snow  <= 1'b0;
    end else begin
      cpu_ack  <= 1'b0;
      snow_hit <= 1'b0;
      if (tick) begin
        case (ph)
          PH_VID_ADDR: begin
            ram_addr <= vid_addr;
            ram_we   <= 1'b0;
          end
          PH_VID_LATCH: vid_data <= ram_q;
          PH_WE_CLR:    ram_we   <= 1'b0;
          default: ;
        endcase

        // a grant on the same tick as the phase-0 video address overrides it (snow)
        case (state)
          SYNC: state <= RUN_IDLE;
          RUN_IDLE: begin
            if (cpu_req && ph == grant_ph) begin
              ram_addr <= cpu_addr;
              ram_we   <= cpu_we;
              ram_d    <= cpu_wdata;
              acc_we   <= cpu_we;
              acc_snow <= snow_mode;
              snow_hit <= snow_mode;
              state    <= RUN_BUSY;
            end
          end
          RUN_BUSY: begin
            if (ph == done_ph) begin
              if (!acc_we) cpu_rdata <= ram_q;
              if (acc_snow) ram_we <= 1'b0;
              cpu_ack <= 1'b1;
              state   <= RUN_IDLE;
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pet_vram_arbiter.sv
// tb/tb_pet_vram_arbiter.sv - self-checking bench for pet_vram_arbiter with a slot-timed RAM and reference memory
module tb_pet_vram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ce_1m_en = 1'b1;
  logic ce_8mp, ce_1m, video_on, cpu_req, cpu_we, cpu_ack, ram_we, snow_hit;
  logic [AW-1:0] vid_addr, cpu_addr, ram_addr;
  logic [DW-1:0] vid_data, cpu_wdata, cpu_rdata, ram_d, ram_q;
  logic [DW-1:0] ram_mem [0:2047];
  logic [DW-1:0] ref_mem [0:2047];
  logic [DW-1:0] last_rd;
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  pet_vram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .ce_8mp    (ce_8mp),
    .ce_1m     (ce_1m),
    .video_on  (video_on),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_d     (ram_d),
    .ram_q     (ram_q),
    .snow_hit  (snow_hit)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h045:   return 8'hA5;
      'h010:   return 8'h55;
      default: return 8'(i * 7 + 13);
    endcase
  endfunction

  // Clock c is a ce_8mp tick when even; its slot phase is (c % 16) / 2.
  initial begin
    forever begin
      ce_8mp = (cyc % 2 == 0);
      ce_1m  = ce_1m_en && (cyc % 16 == 0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  end

  // Single-port RAM: address sampled on a ce_8mp tick, data presented shortly after.
  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rq;
    for (int i = 0; i < 2048; i++) ram_mem[i] = init_byte(i);
    ram_q = '0;
    forever begin
      @(posedge clk);
      if (ce_8mp) begin
        ra = ram_addr;
        rq = ram_mem[ra];
        if (ram_we === 1'b1) ram_mem[ra] = ram_d;
        #1 ram_q = rq;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic after_tick(input int p);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(((cyc - 1) % 2 == 0) && (((cyc - 1) % 16) / 2 == p)) && n < 40);
    check("phase_wait_bound", 32'(n < 40), 32'd1);
  endtask

  function automatic int grant_clk(input int r, input int gp);
    int g;
    g = r + 1;
    while (g % 16 != 2 * gp) g++;
    return g;
  endfunction

  task automatic video_check(input string tag, input logic [AW-1:0] va);
    vid_addr = va;
    after_tick(0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'(va));
    after_tick(2);
    check({tag, "_vid_data"}, 32'(vid_data), 32'(ref_mem[va]));
  endtask

  task automatic cpu_access(input string tag, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output int lat);
    int r, g, gp, n;
    logic seen, snow_seen;
    gp = 4;
`ifdef PET_SNOW_EN
    if (video_on) gp = 0;
`endif
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    r = cyc - 1;
    g = grant_clk(r, gp);
    seen = 1'b0; snow_seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (snow_hit === 1'b1) snow_seen = 1'b1;
      if (cyc - 1 == g) begin
        check({tag, "_grant_addr"}, 32'(ram_addr), 32'(a));
        check({tag, "_grant_we"}, 32'(ram_we), 32'(we));
      end
      if (cyc - 1 == g + 2 && gp == 4) check({tag, "_we_clr"}, 32'(ram_we), 32'd0);
      if (cpu_ack === 1'b1) seen = 1'b1;
    end
    cpu_req = 1'b0;
    lat = (cyc - 1) - r;
    check({tag, "_ack_clk"}, 32'(cyc - 1), 32'(g + 4));
    check({tag, "_snow_hit"}, 32'(snow_seen), 32'(gp == 0));
    if (gp == 0) check({tag, "_snow_vid"}, 32'(vid_data), 32'(ref_mem[a]));
    if (we) ref_mem[a] = d;
    else last_rd = ref_mem[a];
    check({tag, "_rdata"}, 32'(cpu_rdata), 32'(last_rd));
    step();
    check({tag, "_ack_pulse"}, 32'(cpu_ack), 32'd0);
  endtask

  initial begin
    int lat, acks;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic w;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_byte(i);
    video_on = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_addr = '0; last_rd = '0;

    repeat (3) step();
    check("rst_vid_data", 32'(vid_data), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_d", 32'(ram_d), 32'd0);
    check("rst_snow_hit", 32'(snow_hit), 32'd0);

    // Without ce_1m the block must stay parked in SYNC.
    ce_1m_en = 1'b0;
    vid_addr = 11'h123;
    step();
    reset = 1'b0;
    repeat (20) step();
    check("sync_hold_addr", 32'(ram_addr), 32'd0);
    ce_1m_en = 1'b1;
    after_tick(0);
    check("sync_ph0_addr", 32'(ram_addr), 32'h123);
    after_tick(2);
    check("idle_vid_data", 32'(vid_data), 32'(ref_mem[11'h123]));

    after_tick(1);
    cpu_access("rd_045", 1'b0, 11'h045, 8'h00, lat);
    check("rd_045_val", 32'(cpu_rdata), 32'hA5);
    video_check("vid_after_rd", 11'h123);

    after_tick(1);
    cpu_access("wr_7ff", 1'b1, 11'h7FF, 8'h3C, lat);
    repeat ($urandom_range(0, 15)) step();
    cpu_access("rd_7ff", 1'b0, 11'h7FF, 8'h00, lat);
    check("rd_7ff_val", 32'(cpu_rdata), 32'h3C);

    after_tick(4);
    cpu_access("late_req", 1'b0, 11'h045, 8'h00, lat);
    check("late_req_lat", 32'(lat), 32'd20);

    after_tick(3);
    step();
    cpu_access("ph4_req", 1'b1, 11'h0F0, 8'h5A, lat);
    check("ph4_req_lat", 32'(lat), 32'd5);

    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 15)) step();
      a = 11'($urandom_range(11'h060, 11'h7FE));
      d = 8'($urandom);
      w = 1'($urandom);
      cpu_access("rnd", w, a, d, lat);
      if (k % 4 == 3) video_check("rnd_vid", a);
    end

    // Reset on the ph 5 tick of a write: no ack, write strobe gone, resync needed.
    after_tick(1);
    cpu_we = 1'b1; cpu_addr = 11'h0AA; cpu_wdata = 8'h99; cpu_req = 1'b1;
    after_tick(4);
    check("rstw_we_ph4", 32'(ram_we), 32'd1);
    step();
    reset = 1'b1;
    ref_mem[11'h0AA] = 8'h99;
    step();
    check("rstw_we_clr", 32'(ram_we), 32'd0);
    check("rstw_no_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cpu_ack === 1'b1) acks++;
    end
    check("rstw_ack_count", 32'(acks), 32'd0);
    ce_1m_en = 1'b0;
    step();
    reset = 1'b0;
    vid_addr = 11'h155;
    last_rd = '0;
    repeat (24) step();
    check("rstw_sync_hold", 32'(ram_addr), 32'd0);
    ce_1m_en = 1'b1;
    after_tick(0);
    check("rstw_resync_addr", 32'(ram_addr), 32'h155);
    check("rstw_rdata", 32'(cpu_rdata), 32'd0);
    after_tick(2);
    check("rstw_vid_data", 32'(vid_data), 32'(ref_mem[11'h155]));

    // Snow: with the feature built in, video_on moves the grant to ph 0.
    video_on = 1'b1;
    vid_addr = 11'h200;
    after_tick(5);
    cpu_access("snow_on", 1'b0, 11'h010, 8'h00, lat);
    check("snow_on_val", 32'(cpu_rdata), 32'h55);
    video_on = 1'b0;
    after_tick(5);
    cpu_access("snow_off", 1'b0, 11'h010, 8'h00, lat);
    check("snow_off_val", 32'(cpu_rdata), 32'h55);
    video_check("vid_final", 11'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
